// File: rtl/hamming_74_stream_encoder.sv
// Streaming Hamming(7,4) encoder: byte in, two registered codewords out, one nibble per cycle.
// Codeword is valid one edge after its load; output register holds under backpressure, in_ready stalls with it.
module hamming_74_stream_encoder #(
   parameter int CNT_W     = 16,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:1]       out_code,
   output logic             out_fault,
   input  logic             fault_arm,
   input  logic [2:0]       fault_pos,
   output logic [CNT_W-1:0] cw_count
);

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_FIRST  = 2'd1;
   localparam logic [1:0] ST_SECOND = 2'd2;

   function automatic logic [7:1] encode(input logic [3:0] d);
      logic [7:1] c;
      c[3] = d[0];
      c[5] = d[1];
      c[6] = d[2];
      c[7] = d[3];
      c[1] = c[3] ^ c[5] ^ c[7];
      c[2] = c[3] ^ c[6] ^ c[7];
      c[4] = c[5] ^ c[6] ^ c[7];
      return c;
   endfunction

   logic [1:0]       state_q,   state_d;
   logic [7:0]       byte_q,    byte_d;
   logic             out_valid_q, out_valid_d;
   logic [7:1]       out_code_q,  out_code_d;
   logic             out_fault_q, out_fault_d;
   logic             pend_q,    pend_d;
   logic [2:0]       fpos_q,    fpos_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;

   logic             load;
   logic             accept;
   logic             arm_hit;
   logic             do_flip;
   logic [2:0]       flip_pos;
   logic [3:0]       nibble;
   logic [7:1]       flip_mask;

   always_comb begin
      load     = (state_q != ST_EMPTY) & (~out_valid_q | out_ready);
      in_ready = (state_q == ST_EMPTY) | ((state_q == ST_SECOND) & load);
      accept   = in_valid & in_ready;
      arm_hit  = fault_arm & (fault_pos != 3'd0);

      // A same-cycle arm takes priority over an older pending position
      do_flip  = arm_hit | pend_q;
      flip_pos = arm_hit ? fault_pos : fpos_q;
      for (int i = 1; i <= 7; i++) begin
         flip_mask[i] = do_flip & (flip_pos == 3'(i));
      end

      if ((state_q == ST_FIRST) == LSB_FIRST) begin
         nibble = byte_q[3:0];
      end else begin
         nibble = byte_q[7:4];
      end

      state_d = state_q;
      unique case (state_q)
         ST_EMPTY:  if (accept) state_d = ST_FIRST;
         ST_FIRST:  if (load)   state_d = ST_SECOND;
         ST_SECOND: if (load)   state_d = accept ? ST_FIRST : ST_EMPTY;
         default:               state_d = ST_EMPTY;
      endcase

      byte_d = accept ? in_byte : byte_q;

      out_valid_d = out_valid_q;
      out_code_d  = out_code_q;
      out_fault_d = out_fault_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_code_d  = encode(nibble) ^ flip_mask;
         out_fault_d = do_flip;
      end else if (out_valid_q & out_ready) begin
         out_valid_d = 1'b0;
      end

      pend_d = load ? 1'b0 : (pend_q | arm_hit);
      fpos_d = arm_hit ? fault_pos : fpos_q;

      cnt_d = (out_valid_q & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         byte_q      <= '0;
         out_valid_q <= 1'b0;
         out_code_q  <= '0;
         out_fault_q <= 1'b0;
         pend_q      <= 1'b0;
         fpos_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         byte_q      <= byte_d;
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_fault_q <= out_fault_d;
         pend_q      <= pend_d;
         fpos_q      <= fpos_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_fault = out_fault_q;
   assign cw_count  = cnt_q;

endmodule

// File: tb/tb_hamming_74_stream_encoder.sv
// Bench for hamming_74_stream_encoder: directed bytes, expected codewords queued at accept, checked by a monitor.
module tb_hamming_74_stream_encoder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:1] out_code;
   logic       out_fault;
   logic       fault_arm;
   logic [2:0] fault_pos;
   logic [3:0] cw_count;

   typedef struct {
      logic [7:1] code;
      logic       fault;
      logic [2:0] pos;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk;
   int         n_fail;
   logic [3:0] exp_cnt;
   logic [2:0] pend;
   logic       prev_stall;
   logic [7:1] prev_code;
   logic       prev_fault;

   hamming_74_stream_encoder #(.CNT_W(4), .LSB_FIRST(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_fault (out_fault),
      .fault_arm (fault_arm),
      .fault_pos (fault_pos),
      .cw_count  (cw_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed codewords, vector [7:1]
   function automatic logic [7:1] cw_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h00;  4'h1: return 7'h07;  4'h2: return 7'h19;  4'h3: return 7'h1E;
         4'h4: return 7'h2A;  4'h5: return 7'h2D;  4'h6: return 7'h33;  4'h7: return 7'h34;
         4'h8: return 7'h4B;  4'h9: return 7'h4C;  4'hA: return 7'h52;  4'hB: return 7'h55;
         4'hC: return 7'h61;  4'hD: return 7'h66;  4'hE: return 7'h78;  default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [2:0] syndrome(input logic [7:1] c);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 1; i <= 7; i++) begin
         if (c[i]) s = s ^ 3'(i);
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = 4'd0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_code",  32'(out_code),  32'(prev_code));
               chk("hold_fault", 32'(out_fault), 32'(prev_fault));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_codeword", 32'(out_code), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("code",     32'(out_code),           32'(e.code));
                  chk("fault",    32'(out_fault),          32'(e.fault));
                  chk("syndrome", 32'(syndrome(out_code)), 32'(e.pos));
               end
               chk("cw_count", 32'(cw_count), 32'(exp_cnt));
               exp_cnt = exp_cnt + 4'd1;
            end
            prev_stall = out_valid && !out_ready;
            prev_code  = out_code;
            prev_fault = out_fault;
         end
      end
   endtask

   task automatic push_cw(input logic [3:0] n);
      exp_t       e;
      logic [7:1] m;
      m = '0;
      if (pend != 3'd0) m[pend] = 1'b1;
      e.code  = cw_of(n) ^ m;
      e.fault = (pend != 3'd0);
      e.pos   = pend;
      exp_q.push_back(e);
      pend = 3'd0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_byte(input logic [7:0] b, output int waits);
      logic ok;
      ok       = 1'b0;
      waits    = 0;
      in_valid = 1'b1;
      in_byte  = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         waits++;
      end
      if (!ok) begin
         chk("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      push_cw(b[3:0]);
      push_cw(b[7:4]);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic arm(input logic [2:0] p);
      fault_arm = 1'b1;
      fault_pos = p;
      @(posedge clk);
      #1;
      fault_arm = 1'b0;
      if (p != 3'd0) pend = p;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      chk("idle_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int w;
      logic [7:0] flip_bytes [8];
      n_chk      = 0;
      n_fail     = 0;
      exp_cnt    = 4'd0;
      pend       = 3'd0;
      prev_stall = 1'b0;
      prev_code  = '0;
      prev_fault = 1'b0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_byte    = 8'h00;
      out_ready  = 1'b1;
      fault_arm  = 1'b0;
      fault_pos  = 3'd0;
      flip_bytes = '{8'h00, 8'hA5, 8'h3C, 8'hFF, 8'h12, 8'h69, 8'hE7, 8'h80};
      fork
         monitor();
      join_none

      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_code",  32'(out_code),  32'd0);
      chk("rst_out_fault", 32'(out_fault), 32'd0);
      chk("rst_cw_count",  32'(cw_count),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Encode and order
      send_byte(8'hA5, w);
      wait_idle();
      chk("count_after_a5", 32'(cw_count), 32'd2);

      // Extremes back-to-back, second byte accepted on first byte's second load
      send_byte(8'h00, w);
      send_byte(8'hFF, w);
      chk("no_bubble_waits", 32'(w), 32'd1);
      wait_idle();

      // Backpressure
      out_ready = 1'b0;
      send_byte(8'hA5, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();

      // Fault injection on first codeword, then a no-op arm
      arm(3'd3);
      send_byte(8'hA5, w);
      wait_idle();
      arm(3'd0);
      send_byte(8'h5A, w);
      wait_idle();

      // Exhaustive nibbles
      for (int i = 0; i < 8; i++) begin
         send_byte({4'(2 * i + 1), 4'(2 * i)}, w);
      end
      wait_idle();

      // Single-bit flip at each position
      for (int p = 1; p <= 7; p++) begin
         arm(3'(p));
         send_byte(flip_bytes[p], w);
         wait_idle();
      end

      // Reset while in SECOND with the first codeword stalled
      out_ready = 1'b0;
      send_byte(8'hA5, w);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      pend  = 3'd0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(cw_count),  32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_resume_after_rst", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Counter wrap: 16 transfers, then exactly one more
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(8'h21 * i), w);
      end
      wait_idle();
      chk("wrap_count_16", 32'(cw_count), 32'd0);
      out_ready = 1'b0;
      send_byte(8'h3C, w);
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("wrap_count_17", 32'(cw_count), 32'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("final_count",   32'(cw_count),     32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
